gravsim_regfile: RTL and testbench
==================================

Name: gravsim_regfile

Overview:
- Shared 32-bit register file between the HPS/Avalon host and the gravity-simulation FSM.
- Acts as the responder side of the FSM memory protocol: FSM_re/FSM_we, six address ports, six write-data buses, six read-data buses and clear_accs.
- Also holds the G, PLANET_NUM, START and DONE control words.
- Converts a host write to START into a one-cycle FSM_START pulse.

Parameters:
- DEPTH, 128, physical entries; addresses ≥ NUM_USED read as 0 and ignore writes.
- NUM_USED, 114, implemented entries (0..113).
- MAX_PLANETS, 10, planet slots per attribute.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- FSM_re  in  2  read enable: 1 = group A (ports 1-3), 2 = group B (ports 4-6), 3 = both, 0 = none.
- FSM_we  in  2  write enable, same encoding as FSM_re.
- ADDR1..ADDR6  in  32 each  FSM word addresses; bits [6:0] are used, a nonzero [31:7] means out-of-range.
- DATA1..DATA6  in  32 each  FSM write data.
- DATA1in..DATA6in  out  32 each  FSM read data (registered).
- clear_accs  in  1  zero all acceleration words.
- FSM_DONE  in  1  FSM completion pulse.
- FSM_START  out  1  one-cycle start pulse.
- G  out  32  continuous copy of entry 0.
- PLANET_NUM  out  32  continuous copy of entry 1.
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  host strobes.
- AVL_ADDR  in  7  host word address.
- AVL_WRITEDATA  in  32  host write data.
- AVL_READDATA  out  32  host read data (registered).

Behaviour:
- Map (package constants):
  - G = 0, NUM = 1, START = 2, DONE = 3.
  - Planet i (1..10) is at base + i, with bases MASS = 3, RAD = 13, POS_X/Y/Z = 23/33/43, VEL_X/Y/Z = 53/63/73, ACC_X/Y/Z = 83/93/103.
  - Entries 84..113 are the acceleration words.
- Reset (RESET_N low, asynchronous):
  - All entries are 0.
  - DATA1in..DATA6in, AVL_READDATA and FSM_START are 0.
  - Reset asserted mid-operation discards pending writes and any start pulse.
- FSM reads:
  - On a clock edge with the group enabled, DATAkin is loaded with the entry at ADDRk. Latency is 1 cycle.
  - A group that is not enabled holds its previous value.
  - Read-during-write on the same edge returns the old contents.
  - Out-of-range addresses return 0.
- FSM writes:
  - Committed on the edge for the enabled group.
  - When several ports hit the same address, the highest port number wins (ADDR6 > … > ADDR1).
  - Out-of-range writes are dropped.
- clear_accs: on the edge, entries 84..113 become 0. An FSM write to an acceleration word on the same edge overrides the clear.
- Host access (active only when AVL_CS = 1):
  - Reads: AVL_READDATA is valid the cycle after AVL_READ; otherwise it holds its value.
  - Writes: lowest priority. An FSM write or clear_accs on the same address and edge wins.
- START/DONE handshake:
  - A host write of a nonzero value to START stores 1 and clears DONE to 0.
  - FSM_START goes high on the following cycle for exactly 1 cycle. On that same edge START self-clears to 0.
  - A second START write while FSM_START is high is accepted and produces another pulse on the next cycle (no merging).
  - FSM_DONE high sets DONE to 1; it stays 1 until the next START write.
  - If FSM_DONE and a host START write occur on the same edge, START wins: DONE = 0 and the pulse is issued.
  - Host writes to DONE are ignored.
- G and PLANET_NUM are combinational copies of entries 0 and 1.
  - The FSM may not write entries 0-3. Such writes are dropped.

Decomposition:
- Package gravsim_pkg holds:
  - the offset constants (OFFSET_G … OFFSET_ACC_Z);
  - NUM_USED and MAX_PLANETS;
  - the 2-bit enable encoding typedef (EN_NONE/EN_A/EN_B/EN_AB).
- One natural sub-module: gravsim_start_ctl, which holds the START/DONE registers and the pulse generator.
- The storage array and port muxing stay in gravsim_regfile.

Test Plan:
- Reset, then host writes 0x41200000 to addr 0 and 4 to addr 1 → G = 0x41200000 and PLANET_NUM = 4 on the next cycle; host read of addr 1 returns 4 one cycle after AVL_READ.
- FSM_we = 3 with ADDR1..6 = 24,34,44,25,35,45 and data 0x3f800000 / 0xbf800000, then FSM_re = 3 → DATA1in..6in match one cycle after the re edge; re = 1 leaves DATA4in..6in unchanged.
- Preload ACC entries 84, 94 and 113 with 0x3f800000, then pulse clear_accs while FSM_we = 1 writes 0x40000000 to addr 85 → 84, 94 and 113 read 0 and 85 reads 0x40000000.
- Host writes 1 to START → FSM_START is high for exactly one cycle, starting the cycle after the write, and START reads 0 afterwards; FSM_DONE pulse → DONE reads 1; a new START write → DONE reads 0.
- Same-address conflict: FSM_we = 3 with ADDR1 = ADDR4 = 30, DATA1 = 1, DATA4 = 2, plus a host write of 3 to 30 on the same edge → entry 30 = 2. Read-during-write on 30 returns the old value.
- Assert RESET_N low asynchronously mid-clock while FSM_we = 3 → all outputs 0 immediately and all entries 0 after release; ADDR1 = 200 read returns 0.

Source files
------------

// File: rtl/gravsim_pkg.sv
// Shared constants and types for the gravity-simulation register file:
// word map, sizes and the two-group FSM enable encoding.
package gravsim_pkg;

   localparam int unsigned DEPTH       = 128;
   localparam int unsigned ADDR_W      = $clog2(DEPTH);
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned NUM_PORTS   = 6;
   localparam int unsigned MAX_PLANETS = 10;

   // Control words, then ten-slot attribute blocks; planet i lives at base + i.
   localparam int unsigned OFFSET_G     = 0;
   localparam int unsigned OFFSET_NUM   = 1;
   localparam int unsigned OFFSET_START = 2;
   localparam int unsigned OFFSET_DONE  = 3;
   localparam int unsigned OFFSET_MASS  = OFFSET_DONE;
   localparam int unsigned OFFSET_RAD   = OFFSET_MASS  + MAX_PLANETS;
   localparam int unsigned OFFSET_POS_X = OFFSET_RAD   + MAX_PLANETS;
   localparam int unsigned OFFSET_POS_Y = OFFSET_POS_X + MAX_PLANETS;
   localparam int unsigned OFFSET_POS_Z = OFFSET_POS_Y + MAX_PLANETS;
   localparam int unsigned OFFSET_VEL_X = OFFSET_POS_Z + MAX_PLANETS;
   localparam int unsigned OFFSET_VEL_Y = OFFSET_VEL_X + MAX_PLANETS;
   localparam int unsigned OFFSET_VEL_Z = OFFSET_VEL_Y + MAX_PLANETS;
   localparam int unsigned OFFSET_ACC_X = OFFSET_VEL_Z + MAX_PLANETS;
   localparam int unsigned OFFSET_ACC_Y = OFFSET_ACC_X + MAX_PLANETS;
   localparam int unsigned OFFSET_ACC_Z = OFFSET_ACC_Y + MAX_PLANETS;

   localparam int unsigned NUM_USED     = OFFSET_ACC_Z + MAX_PLANETS + 1;
   localparam int unsigned ACC_FIRST    = OFFSET_ACC_X + 1;
   localparam int unsigned FSM_WR_FIRST = OFFSET_DONE + 1;

   typedef enum logic [1:0] {
      EN_NONE = 2'd0,
      EN_A    = 2'd1,
      EN_B    = 2'd2,
      EN_AB   = 2'd3
   } en_t;

   // Ports 0..2 form group A, ports 3..5 group B.
   function automatic logic port_en(input en_t en, input int unsigned port);
      if (port < 3) return (en == EN_A) || (en == EN_AB);
      return (en == EN_B) || (en == EN_AB);
   endfunction

   function automatic logic in_range(input logic [DATA_W-1:0] a);
      return (a[DATA_W-1:ADDR_W] == '0) && (a[ADDR_W-1:0] < ADDR_W'(NUM_USED));
   endfunction

endpackage

// File: rtl/gravsim_start_ctl.sv
// START/DONE control words and the one-cycle FSM start pulse generator.
module gravsim_start_ctl
   import gravsim_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_wr,
   input  logic              done_in,
   output logic [DATA_W-1:0] start_word,
   output logic [DATA_W-1:0] done_word,
   output logic              fsm_start
);

   logic start_q;
   logic done_q;

   // A stored START becomes the pulse one edge later and clears itself on that edge;
   // a fresh host write always takes priority over both self-clear and FSM done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         fsm_start <= 1'b0;
      end else begin
         fsm_start <= start_q;
         if (start_wr) begin
            start_q <= 1'b1;
            done_q  <= 1'b0;
         end else begin
            start_q <= 1'b0;
            if (done_in) done_q <= 1'b1;
         end
      end
   end

   assign start_word = DATA_W'(start_q);
   assign done_word  = DATA_W'(done_q);

endmodule

// File: rtl/gravsim_regfile.sv
// Register file shared between the Avalon host and the gravity FSM:
// six FSM read/write ports in two groups, one host port, START/DONE handshake.
module gravsim_regfile
   import gravsim_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [1:0]        FSM_re,
   input  logic [1:0]        FSM_we,
   input  logic [DATA_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] ADDR2,
   input  logic [DATA_W-1:0] ADDR3,
   input  logic [DATA_W-1:0] ADDR4,
   input  logic [DATA_W-1:0] ADDR5,
   input  logic [DATA_W-1:0] ADDR6,
   input  logic [DATA_W-1:0] DATA1,
   input  logic [DATA_W-1:0] DATA2,
   input  logic [DATA_W-1:0] DATA3,
   input  logic [DATA_W-1:0] DATA4,
   input  logic [DATA_W-1:0] DATA5,
   input  logic [DATA_W-1:0] DATA6,
   output logic [DATA_W-1:0] DATA1in,
   output logic [DATA_W-1:0] DATA2in,
   output logic [DATA_W-1:0] DATA3in,
   output logic [DATA_W-1:0] DATA4in,
   output logic [DATA_W-1:0] DATA5in,
   output logic [DATA_W-1:0] DATA6in,
   input  logic              clear_accs,
   input  logic              FSM_DONE,
   output logic              FSM_START,
   output logic [DATA_W-1:0] G,
   output logic [DATA_W-1:0] PLANET_NUM,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [DATA_W-1:0] AVL_WRITEDATA,
   output logic [DATA_W-1:0] AVL_READDATA
);

   logic [DATA_W-1:0] addr_a  [NUM_PORTS];
   logic [DATA_W-1:0] wdata_a [NUM_PORTS];
   logic [DATA_W-1:0] rdata_q [NUM_PORTS];
   logic [DATA_W-1:0] mem     [NUM_USED];
   logic [DATA_W-1:0] mem_d   [NUM_USED];
   logic [DATA_W-1:0] start_word;
   logic [DATA_W-1:0] done_word;
   en_t               re_en;
   en_t               we_en;
   logic              host_wr;
   logic              host_rd;
   logic              start_wr;

   assign addr_a[0] = ADDR1;
   assign addr_a[1] = ADDR2;
   assign addr_a[2] = ADDR3;
   assign addr_a[3] = ADDR4;
   assign addr_a[4] = ADDR5;
   assign addr_a[5] = ADDR6;

   assign wdata_a[0] = DATA1;
   assign wdata_a[1] = DATA2;
   assign wdata_a[2] = DATA3;
   assign wdata_a[3] = DATA4;
   assign wdata_a[4] = DATA5;
   assign wdata_a[5] = DATA6;

   assign DATA1in = rdata_q[0];
   assign DATA2in = rdata_q[1];
   assign DATA3in = rdata_q[2];
   assign DATA4in = rdata_q[3];
   assign DATA5in = rdata_q[4];
   assign DATA6in = rdata_q[5];

   assign re_en    = en_t'(FSM_re);
   assign we_en    = en_t'(FSM_we);
   assign host_wr  = AVL_CS & AVL_WRITE;
   assign host_rd  = AVL_CS & AVL_READ;
   assign start_wr = host_wr && (AVL_ADDR == ADDR_W'(OFFSET_START)) && (AVL_WRITEDATA != '0);

   // START and DONE live in the control block; the array slots 2 and 3 stay at zero.
   function automatic logic [DATA_W-1:0] rd_word(input logic [DATA_W-1:0] a);
      logic [ADDR_W-1:0] idx;
      idx = a[ADDR_W-1:0];
      if (!in_range(a))                   return '0;
      if (idx == ADDR_W'(OFFSET_START))   return start_word;
      if (idx == ADDR_W'(OFFSET_DONE))    return done_word;
      return mem[idx];
   endfunction

   // Next-state per entry: host lowest, then acceleration clear, then FSM ports in rising priority.
   always_comb begin
      for (int unsigned e = 0; e < NUM_USED; e++) begin
         mem_d[e] = mem[e];
         if (host_wr && (AVL_ADDR == ADDR_W'(e)) && (e != OFFSET_START) && (e != OFFSET_DONE))
            mem_d[e] = AVL_WRITEDATA;
         if (clear_accs && (e >= ACC_FIRST))
            mem_d[e] = '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (port_en(we_en, p) && in_range(addr_a[p]) &&
                (addr_a[p][ADDR_W-1:0] == ADDR_W'(e)) && (e >= FSM_WR_FIRST))
               mem_d[e] = wdata_a[p];
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mem <= '{default: '0};
      end else begin
         mem <= mem_d;
      end
   end

   // Registered read ports; disabled groups and an idle host port hold their last value.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rdata_q      <= '{default: '0};
         AVL_READDATA <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (port_en(re_en, p)) rdata_q[p] <= rd_word(addr_a[p]);
         end
         if (host_rd) AVL_READDATA <= rd_word(DATA_W'(AVL_ADDR));
      end
   end

   assign G          = mem[OFFSET_G];
   assign PLANET_NUM = mem[OFFSET_NUM];

   gravsim_start_ctl u_start_ctl (
      .clk        (CLK),
      .rst_n      (RESET_N),
      .start_wr   (start_wr),
      .done_in    (FSM_DONE),
      .start_word (start_word),
      .done_word  (done_word),
      .fsm_start  (FSM_START)
   );

endmodule

// File: tb/tb_gravsim_regfile.sv
// Directed self-checking bench for gravsim_regfile with hand-computed expectations.
module tb_gravsim_regfile;

   logic        CLK;
   logic        RESET_N;
   logic [1:0]  FSM_re, FSM_we;
   logic [31:0] ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6;
   logic [31:0] DATA1, DATA2, DATA3, DATA4, DATA5, DATA6;
   logic [31:0] DATA1in, DATA2in, DATA3in, DATA4in, DATA5in, DATA6in;
   logic        clear_accs, FSM_DONE, FSM_START;
   logic [31:0] G, PLANET_NUM;
   logic        AVL_CS, AVL_READ, AVL_WRITE;
   logic [6:0]  AVL_ADDR;
   logic [31:0] AVL_WRITEDATA, AVL_READDATA;

   int nerr = 0;
   int nchk = 0;
   logic [31:0] rd;

   localparam logic [31:0] P1 = 32'h3f80_0000;
   localparam logic [31:0] M1 = 32'hbf80_0000;

   gravsim_regfile dut (
      .CLK(CLK), .RESET_N(RESET_N), .FSM_re(FSM_re), .FSM_we(FSM_we),
      .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3), .ADDR4(ADDR4), .ADDR5(ADDR5), .ADDR6(ADDR6),
      .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3), .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
      .DATA1in(DATA1in), .DATA2in(DATA2in), .DATA3in(DATA3in),
      .DATA4in(DATA4in), .DATA5in(DATA5in), .DATA6in(DATA6in),
      .clear_accs(clear_accs), .FSM_DONE(FSM_DONE), .FSM_START(FSM_START),
      .G(G), .PLANET_NUM(PLANET_NUM),
      .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
      .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
      AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
      tick();
      AVL_CS = 1'b0; AVL_WRITE = 1'b0;
   endtask

   task automatic host_rd(input logic [6:0] a, output logic [31:0] d);
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
      tick();
      AVL_CS = 1'b0; AVL_READ = 1'b0;
      d = AVL_READDATA;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESET_N = 1'b0; FSM_re = 2'd0; FSM_we = 2'd0; clear_accs = 1'b0; FSM_DONE = 1'b0;
      AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
      {ADDR1, ADDR2, ADDR3, ADDR4, ADDR5, ADDR6} = '0;
      {DATA1, DATA2, DATA3, DATA4, DATA5, DATA6} = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_g", G, 32'h0);
      chk("rst_data1in", DATA1in, 32'h0);
      chk("rst_readdata", AVL_READDATA, 32'h0);
      chk("rst_start", {31'h0, FSM_START}, 32'h0);
      RESET_N = 1'b1;
      tick();

      // Host setup of G and PLANET_NUM
      host_wr(7'd0, 32'h4120_0000);
      chk("g_copy", G, 32'h4120_0000);
      host_wr(7'd1, 32'd4);
      chk("num_copy", PLANET_NUM, 32'd4);
      host_rd(7'd1, rd);
      chk("host_rd_num", rd, 32'd4);

      // Six-port FSM write then read
      ADDR1 = 24; ADDR2 = 34; ADDR3 = 44; ADDR4 = 25; ADDR5 = 35; ADDR6 = 45;
      DATA1 = P1; DATA2 = M1; DATA3 = P1; DATA4 = M1; DATA5 = P1; DATA6 = M1;
      FSM_we = 2'd3;
      tick();
      FSM_we = 2'd0; FSM_re = 2'd3;
      tick();
      FSM_re = 2'd0;
      chk("rd_p1", DATA1in, P1);
      chk("rd_p2", DATA2in, M1);
      chk("rd_p3", DATA3in, P1);
      chk("rd_p4", DATA4in, M1);
      chk("rd_p5", DATA5in, P1);
      chk("rd_p6", DATA6in, M1);
      ADDR1 = 45; ADDR4 = 0; ADDR5 = 1; ADDR6 = 0; FSM_re = 2'd1;
      tick();
      FSM_re = 2'd0;
      chk("grpA_rd", DATA1in, M1);
      chk("grpB_hold4", DATA4in, M1);
      chk("grpB_hold5", DATA5in, P1);
      chk("grpB_hold6", DATA6in, M1);

      // clear_accs with an overriding FSM write
      host_wr(7'd84, P1); host_wr(7'd94, P1); host_wr(7'd113, P1); host_wr(7'd85, P1);
      ADDR1 = 85; DATA1 = 32'h4000_0000; ADDR2 = 200; ADDR3 = 200;
      FSM_we = 2'd1; clear_accs = 1'b1;
      tick();
      FSM_we = 2'd0; clear_accs = 1'b0;
      host_rd(7'd84, rd);  chk("clr_84", rd, 32'h0);
      host_rd(7'd94, rd);  chk("clr_94", rd, 32'h0);
      host_rd(7'd113, rd); chk("clr_113", rd, 32'h0);
      host_rd(7'd85, rd);  chk("clr_ovr_85", rd, 32'h4000_0000);
      host_rd(7'd44, rd);  chk("keep_44", rd, P1);
      host_rd(7'd72, rd);  chk("oor_wr_alias", rd, 32'h0);

      // FSM may not write the control words; host writes above NUM_USED vanish
      ADDR1 = 0; DATA1 = 32'hdead_beef; FSM_we = 2'd1;
      tick();
      FSM_we = 2'd0;
      chk("fsm_wr_g_drop", G, 32'h4120_0000);
      host_wr(7'd120, 32'h5555_5555);
      host_rd(7'd120, rd); chk("host_oor_rd", rd, 32'h0);

      // START / DONE handshake
      host_wr(7'd2, 32'd1);
      chk("start_lat", {31'h0, FSM_START}, 32'h0);
      tick();
      chk("start_pulse", {31'h0, FSM_START}, 32'h1);
      tick();
      chk("start_end", {31'h0, FSM_START}, 32'h0);
      host_rd(7'd2, rd); chk("start_selfclr", rd, 32'h0);
      FSM_DONE = 1'b1;
      tick();
      FSM_DONE = 1'b0;
      host_rd(7'd3, rd); chk("done_set", rd, 32'h1);
      host_wr(7'd3, 32'h0);
      host_rd(7'd3, rd); chk("done_host_ign", rd, 32'h1);
      host_wr(7'd2, 32'd5);
      host_rd(7'd3, rd); chk("done_clr", rd, 32'h0);
      chk("start_pulse2", {31'h0, FSM_START}, 32'h1);
      tick();

      // Back-to-back START writes give two separate pulses
      host_wr(7'd2, 32'd1);
      tick();
      chk("b2b_pulse_a", {31'h0, FSM_START}, 32'h1);
      host_wr(7'd2, 32'd1);
      chk("b2b_gap", {31'h0, FSM_START}, 32'h0);
      tick();
      chk("b2b_pulse_b", {31'h0, FSM_START}, 32'h1);
      tick();
      chk("b2b_end", {31'h0, FSM_START}, 32'h0);

      // FSM_DONE and START on the same edge
      FSM_DONE = 1'b1;
      tick();
      host_wr(7'd2, 32'd1);
      FSM_DONE = 1'b0;
      host_rd(7'd3, rd); chk("start_beats_done", rd, 32'h0);
      chk("start_beats_pulse", {31'h0, FSM_START}, 32'h1);
      tick();

      // Same-address conflict with read-during-write
      host_wr(7'd30, 32'h1234_5678);
      ADDR1 = 30; ADDR4 = 30; ADDR2 = 200; ADDR3 = 200; ADDR5 = 200; ADDR6 = 200;
      DATA1 = 32'd1; DATA4 = 32'd2;
      FSM_we = 2'd3; FSM_re = 2'd1;
      AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 7'd30; AVL_WRITEDATA = 32'd3;
      tick();
      FSM_we = 2'd0; FSM_re = 2'd0; AVL_CS = 1'b0; AVL_WRITE = 1'b0;
      chk("rdw_old", DATA1in, 32'h1234_5678);
      host_rd(7'd30, rd); chk("conflict_p4", rd, 32'd2);

      // Out-of-range FSM address (bit 7 set) must not alias entry 24
      ADDR1 = 32'h0000_0098; FSM_re = 2'd1;
      tick();
      chk("fsm_oor_rd", DATA1in, 32'h0);
      ADDR1 = 24;
      tick();
      FSM_re = 2'd0;
      chk("fsm_rd_24", DATA1in, P1);

      // Asynchronous reset mid-cycle with writes pending
      ADDR1 = 24; ADDR2 = 34; ADDR3 = 44; ADDR4 = 25; ADDR5 = 35; ADDR6 = 45;
      DATA1 = 32'h1111_1111; DATA2 = 32'h1111_1111; DATA3 = 32'h1111_1111;
      DATA4 = 32'h1111_1111; DATA5 = 32'h1111_1111; DATA6 = 32'h1111_1111;
      FSM_we = 2'd3;
      #3;
      RESET_N = 1'b0;
      #1;
      chk("arst_data1in", DATA1in, 32'h0);
      chk("arst_readdata", AVL_READDATA, 32'h0);
      chk("arst_g", G, 32'h0);
      chk("arst_num", PLANET_NUM, 32'h0);
      FSM_we = 2'd0;
      tick();
      RESET_N = 1'b1;
      tick();
      host_rd(7'd24, rd); chk("arst_e24", rd, 32'h0);
      host_rd(7'd30, rd); chk("arst_e30", rd, 32'h0);
      ADDR1 = 200; FSM_re = 2'd1;
      tick();
      FSM_re = 2'd0;
      chk("arst_oor200", DATA1in, 32'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
